// File: rtl/reg_ctx_pkg.sv
// Shared definitions for the register-context save/restore engine.
// Holds the command opcodes, FSM state encoding and register index width.
// Optional feature macro: CTX_CHECKSUM_EN (checksum byte appended after the registers).
package reg_ctx_pkg;

  localparam int CTX_NUM_REGS = 4;
  localparam int IDX_W        = 2;  // register select width on the rf ports

  localparam logic CTX_OP_SAVE    = 1'b0;
  localparam logic CTX_OP_RESTORE = 1'b1;

  typedef logic [2:0] ctx_state_t;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_RD_REQ    = 3'd1;
  localparam logic [2:0] ST_RD_WAIT   = 3'd2;
  localparam logic [2:0] ST_MEM_WR    = 3'd3;
  localparam logic [2:0] ST_MEM_RD    = 3'd4;
  localparam logic [2:0] ST_MEM_RWAIT = 3'd5;
  localparam logic [2:0] ST_RF_WR     = 3'd6;
  localparam logic [2:0] ST_DONE      = 3'd7;

endpackage

// File: rtl/reg_ctx_csum.sv
// XOR checksum accumulator used by the context engine when CTX_CHECKSUM_EN is defined.
// Latency: sum updates the cycle after acc_i; err_o sets the cycle after a failing cmp_i.
// Backpressure: none; strobes are taken as given. err_o is sticky until clr_i or reset.
// Ports: clk/reset; clr_i clears sum and error; acc_i/acc_data_i fold a byte into the sum;
//        cmp_i/cmp_data_i compare a stored checksum with the running sum; sum_o, err_o.
module reg_ctx_csum #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          acc_i,
  input  logic [DW-1:0] acc_data_i,
  input  logic          cmp_i,
  input  logic [DW-1:0] cmp_data_i,
  output logic [DW-1:0] sum_o,
  output logic          err_o
);

  logic [DW-1:0] sum_q, sum_d;
  logic          err_q, err_d;

  always_comb begin
    sum_d = sum_q;
    err_d = err_q;
    if (clr_i) begin
      sum_d = '0;
      err_d = 1'b0;
    end else begin
      if (acc_i) sum_d = sum_q ^ acc_data_i;
      if (cmp_i && (cmp_data_i != sum_q)) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q <= '0;
      err_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      err_q <= err_d;
    end
  end

  assign sum_o = sum_q;
  assign err_o = err_q;

endmodule

// File: rtl/reg_ctx_engine.sv
// Context save/restore engine: moves R0..R3 between the register file and memory at base+idx.
// Latency: 3 cycles per register with gnt tied high; done pulses 13 cycles after accept.
// Backpressure: holds mem_req/addr/we/wdata until mem_gnt; waits indefinitely for mem_rvalid.
// Ports: cmd_* handshake (op, base), busy/done/ctx_err status, rf_rd_*/rf_wr_* register file
//        master ports, mem_* request/grant/rvalid memory master port.
// Config: CTX_CHECKSUM_EN adds an XOR checksum byte at base+NUM_REGS; default build has none.
module reg_ctx_engine
  import reg_ctx_pkg::*;
#(
  parameter int NUM_REGS = CTX_NUM_REGS,
  parameter int DW       = 8,
  parameter int AW       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_op,
  input  logic [AW-1:0]    cmd_base,
  output logic             busy,
  output logic             done,
  output logic             ctx_err,
  output logic             rf_rd_en,
  output logic [IDX_W-1:0] rf_rd_sel,
  input  logic [DW-1:0]    rf_rd_data,
  output logic             rf_wr_en,
  output logic [IDX_W-1:0] rf_wr_sel,
  output logic [DW-1:0]    rf_wr_data,
  output logic             mem_req,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  input  logic             mem_gnt,
  input  logic             mem_rvalid,
  input  logic [DW-1:0]    mem_rdata
);

  // One spare index bit so idx can point at the checksum slot (idx == NUM_REGS).
  localparam int             CW       = IDX_W + 1;
  localparam logic [CW-1:0]  LAST_IDX = CW'(NUM_REGS - 1);

  ctx_state_t     state_q, state_d;
  logic [CW-1:0]  idx_q, idx_d;
  logic [AW-1:0]  base_q, base_d;
  logic [DW-1:0]  buf_q, buf_d;   // wbuf on SAVE, captured read data on RESTORE
  logic           accept;
  logic           in_csum_slot;

  assign accept = cmd_valid && (state_q == ST_IDLE);

`ifdef CTX_CHECKSUM_EN
  localparam logic [CW-1:0] CSUM_IDX = CW'(NUM_REGS);

  logic [DW-1:0] csum_sum;
  logic          csum_err;
  logic          csum_acc;
  logic          csum_cmp;
  logic [DW-1:0] csum_acc_data;

  assign in_csum_slot  = (idx_q == CSUM_IDX);
  // SAVE folds each byte as it leaves the rf; RESTORE folds each byte as it arrives from memory.
  assign csum_acc      = (state_q == ST_RD_WAIT) ||
                         ((state_q == ST_MEM_RWAIT) && mem_rvalid && !in_csum_slot);
  assign csum_acc_data = (state_q == ST_RD_WAIT) ? rf_rd_data : mem_rdata;
  assign csum_cmp      = (state_q == ST_MEM_RWAIT) && mem_rvalid && in_csum_slot;

  reg_ctx_csum #(.DW(DW)) u_csum (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (accept),
    .acc_i      (csum_acc),
    .acc_data_i (csum_acc_data),
    .cmp_i      (csum_cmp),
    .cmp_data_i (mem_rdata),
    .sum_o      (csum_sum),
    .err_o      (csum_err)
  );

  assign ctx_err   = csum_err;
  assign mem_wdata = in_csum_slot ? csum_sum : buf_q;
`else
  assign in_csum_slot = 1'b0;
  assign ctx_err      = 1'b0;
  assign mem_wdata    = buf_q;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    base_d  = base_q;
    buf_d   = buf_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          idx_d   = '0;
          base_d  = cmd_base;
          // The opcode only selects the first state, so it needs no register of its own.
          state_d = (cmd_op == CTX_OP_RESTORE) ? ST_MEM_RD : ST_RD_REQ;
        end
      end
      ST_RD_REQ: state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        buf_d   = rf_rd_data;
        state_d = ST_MEM_WR;
      end
      ST_MEM_WR: begin
        if (mem_gnt) begin
          if (in_csum_slot) begin
            state_d = ST_DONE;
          end else if (idx_q == LAST_IDX) begin
`ifdef CTX_CHECKSUM_EN
            idx_d   = CSUM_IDX;   // stay in MEM_WR for the checksum byte
`else
            state_d = ST_DONE;
`endif
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_RD_REQ;
          end
        end
      end
      ST_MEM_RD: begin
        if (mem_gnt) state_d = ST_MEM_RWAIT;
      end
      ST_MEM_RWAIT: begin
        if (mem_rvalid) begin
          buf_d   = mem_rdata;
          // The checksum byte is only compared, never written to the rf.
          state_d = in_csum_slot ? ST_DONE : ST_RF_WR;
        end
      end
      ST_RF_WR: begin
        if (idx_q == LAST_IDX) begin
`ifdef CTX_CHECKSUM_EN
          idx_d   = CSUM_IDX;
          state_d = ST_MEM_RD;
`else
          state_d = ST_DONE;
`endif
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_MEM_RD;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      base_q  <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
      buf_q   <= buf_d;
    end
  end

  // Read and write rf strobes come from disjoint states, so they never overlap.
  assign cmd_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign rf_rd_en   = (state_q == ST_RD_REQ);
  assign rf_rd_sel  = idx_q[IDX_W-1:0];
  assign rf_wr_en   = (state_q == ST_RF_WR);
  assign rf_wr_sel  = idx_q[IDX_W-1:0];
  assign rf_wr_data = buf_q;
  assign mem_req    = (state_q == ST_MEM_WR) || (state_q == ST_MEM_RD);
  assign mem_we     = (state_q == ST_MEM_WR);
  // Natural AW-bit wrap of base+idx.
  assign mem_addr   = base_q + AW'(idx_q);

endmodule

// File: tb/tb_reg_ctx_engine.sv
// Directed bench for reg_ctx_engine with a register file model and a memory model.
// Memory grants after a programmable stall; read data returns one cycle after the grant.
// Build with CTX_CHECKSUM_EN defined to exercise the checksum variant.
module tb_reg_ctx_engine;

`ifdef CTX_CHECKSUM_EN
  localparam int NXFER = 5;
  localparam int SAVE_LAT = 14;
  localparam int RST_LAT = 15;
`else
  localparam int NXFER = 4;
  localparam int SAVE_LAT = 13;
  localparam int RST_LAT = 13;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_op = 1'b0;
  logic [7:0] cmd_base = 8'h00;
  logic       busy, done, ctx_err;
  logic       rf_rd_en, rf_wr_en;
  logic [1:0] rf_rd_sel, rf_wr_sel;
  logic [7:0] rf_rd_data, rf_wr_data;
  logic       mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  reg_ctx_engine dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_base(cmd_base),
    .busy(busy), .done(done), .ctx_err(ctx_err),
    .rf_rd_en(rf_rd_en), .rf_rd_sel(rf_rd_sel), .rf_rd_data(rf_rd_data),
    .rf_wr_en(rf_wr_en), .rf_wr_sel(rf_wr_sel), .rf_wr_data(rf_wr_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  // ---------------- models and monitors ----------------
  logic [7:0] rf_m [4];
  logic [7:0] mem_m [256];
  logic       ld_rf = 1'b0, ld_mem = 1'b0;
  logic [7:0] ld_addr = 8'h00, ld_dat = 8'h00;
  int         gnt_dly = 0;
  int         wait_cnt = 0;
  int         acc_n = 0, rf_wr_n = 0, wr_n = 0, stab_viol = 0, ovl_viol = 0;
  logic [7:0] wr_log [64];
  logic       stall_q = 1'b0, sv_we = 1'b0;
  logic [7:0] sv_addr = 8'h00, sv_wdata = 8'h00;

  assign mem_gnt = mem_req && (wait_cnt >= gnt_dly);

  always @(posedge clk) begin
    if (ld_rf) rf_m[ld_addr[1:0]] <= ld_dat;
    else if (rf_wr_en) rf_m[rf_wr_sel] <= rf_wr_data;
    if (rf_rd_en) rf_rd_data <= rf_m[rf_rd_sel];
    if (ld_mem) mem_m[ld_addr] <= ld_dat;
    else if (mem_req && mem_gnt && mem_we) mem_m[mem_addr] <= mem_wdata;
    mem_rvalid <= mem_req && mem_gnt && !mem_we;
    mem_rdata  <= mem_m[mem_addr];
    wait_cnt   <= (!mem_req || mem_gnt) ? 0 : wait_cnt + 1;

    if (!reset && cmd_valid && cmd_ready) acc_n <= acc_n + 1;
    if (rf_wr_en) rf_wr_n <= rf_wr_n + 1;
    if (mem_req && mem_gnt && mem_we) begin
      wr_log[wr_n[5:0]] <= mem_addr;
      wr_n <= wr_n + 1;
    end
    if (rf_rd_en && rf_wr_en) ovl_viol <= ovl_viol + 1;
    if (stall_q && (!mem_req || mem_addr != sv_addr || mem_we != sv_we || mem_wdata != sv_wdata))
      stab_viol <= stab_viol + 1;
    stall_q  <= !reset && mem_req && !mem_gnt;
    sv_addr  <= mem_addr;
    sv_we    <= mem_we;
    sv_wdata <= mem_wdata;
  end

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic load(input bit is_rf, input logic [7:0] addr, input logic [7:0] dat);
    @(negedge clk);
    ld_rf = is_rf; ld_mem = !is_rf; ld_addr = addr; ld_dat = dat;
    @(negedge clk);
    ld_rf = 1'b0; ld_mem = 1'b0;
  endtask

  task automatic load_rf4(input logic [7:0] a, b, c, d);
    load(1'b1, 8'd0, a); load(1'b1, 8'd1, b); load(1'b1, 8'd2, c); load(1'b1, 8'd3, d);
  endtask

  // Issues one command and returns the cycle (1 = first cycle after accept) in which done is seen.
  task automatic run_cmd(input logic op, input logic [7:0] base, input bit hold, output int lat);
    @(negedge clk);
    cmd_op = op; cmd_base = base; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = hold;
    cmd_base  = ~base;   // engine must use the value latched at accept
    lat = 0;
    for (int k = 1; k <= 400; k++) begin
      if (done) begin lat = k; break; end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    if (lat == 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  int lat, snap, snap2;
  bit found;

  initial begin
    // ---- reset state ----
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ctx_err", ctx_err, 0);
    chk("rst_rf_rd_en", rf_rd_en, 0);
    chk("rst_rf_wr_en", rf_wr_en, 0);
    chk("rst_mem_req", mem_req, 0);

    // ---- save 11,22,33,44 to 0x40 ----
    load_rf4(8'h11, 8'h22, 8'h33, 8'h44);
    load(1'b0, 8'h44, 8'h5A);
    run_cmd(1'b0, 8'h40, 1'b0, lat);
    chk("save_latency", lat, SAVE_LAT);
    chk("save_m40", mem_m[8'h40], 8'h11);
    chk("save_m41", mem_m[8'h41], 8'h22);
    chk("save_m42", mem_m[8'h42], 8'h33);
    chk("save_m43", mem_m[8'h43], 8'h44);
`ifdef CTX_CHECKSUM_EN
    chk("save_csum_m44", mem_m[8'h44], 8'h44);
`else
    chk("save_no_extra_m44", mem_m[8'h44], 8'h5A);
`endif

    // ---- restore A1,B2,C3,D4 from 0x80 ----
    load(1'b0, 8'h80, 8'hA1); load(1'b0, 8'h81, 8'hB2);
    load(1'b0, 8'h82, 8'hC3); load(1'b0, 8'h83, 8'hD4);
    load(1'b0, 8'h84, 8'h04);   // correct XOR of the four bytes
    snap = rf_wr_n;
    run_cmd(1'b1, 8'h80, 1'b0, lat);
    chk("rst_latency", lat, RST_LAT);
    chk("restore_ctx_err", ctx_err, 0);
    @(negedge clk);
    chk("restore_r0", rf_m[0], 8'hA1);
    chk("restore_r1", rf_m[1], 8'hB2);
    chk("restore_r2", rf_m[2], 8'hC3);
    chk("restore_r3", rf_m[3], 8'hD4);
    chk("restore_wr_count", rf_wr_n - snap, 4);

    // ---- backpressure: grant after 5 stalled cycles ----
    gnt_dly = 5;
    load_rf4(8'h5A, 8'hA5, 8'h3C, 8'hC3);
    run_cmd(1'b0, 8'h20, 1'b0, lat);
    chk("bp_save_latency", lat, SAVE_LAT + 5 * NXFER);
    chk("bp_m20", mem_m[8'h20], 8'h5A);
    chk("bp_m23", mem_m[8'h23], 8'hC3);
    load_rf4(8'h00, 8'h00, 8'h00, 8'h00);
    run_cmd(1'b1, 8'h20, 1'b0, lat);
    chk("bp_rst_latency", lat, RST_LAT + 5 * NXFER);
    chk("bp_ctx_err", ctx_err, 0);
    @(negedge clk);
    chk("bp_r1", rf_m[1], 8'hA5);
    chk("bp_r2", rf_m[2], 8'h3C);
    chk("bp_stable", stab_viol, 0);
    gnt_dly = 0;

    // ---- address wrap at 0xFE with cmd_valid held high while busy ----
    snap  = wr_n;
    snap2 = acc_n;
    run_cmd(1'b0, 8'hFE, 1'b1, lat);
    @(negedge clk);
    chk("wrap_accepts", acc_n - snap2, 1);
    chk("wrap_a0", wr_log[6'(snap)], 8'hFE);
    chk("wrap_a1", wr_log[6'(snap + 1)], 8'hFF);
    chk("wrap_a2", wr_log[6'(snap + 2)], 8'h00);
    chk("wrap_a3", wr_log[6'(snap + 3)], 8'h01);
    chk("wrap_mFE", mem_m[8'hFE], 8'h5A);
    chk("wrap_m01", mem_m[8'h01], 8'hC3);

    // ---- reset during restore at idx 2 ----
    load_rf4(8'h55, 8'h55, 8'h55, 8'h55);
    load(1'b0, 8'h90, 8'h01); load(1'b0, 8'h91, 8'h02);
    load(1'b0, 8'h92, 8'h03); load(1'b0, 8'h93, 8'h04);
    @(negedge clk);
    cmd_op = 1'b1; cmd_base = 8'h90; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (mem_req && mem_addr == 8'h92) begin found = 1'b1; break; end
      @(negedge clk);
    end
    chk("abort_reached_idx2", found, 1);
    reset = 1'b1;
    snap = rf_wr_n;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_cmd_ready", cmd_ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_mem_req", mem_req, 0);
    repeat (6) @(negedge clk);
    chk("abort_no_rf_wr", rf_wr_n - snap, 0);
    chk("abort_r0", rf_m[0], 8'h01);
    chk("abort_r1", rf_m[1], 8'h02);
    chk("abort_r2", rf_m[2], 8'h55);
    chk("abort_r3", rf_m[3], 8'h55);

`ifdef CTX_CHECKSUM_EN
    // ---- checksum: save, corrupted restore, clean restore ----
    load_rf4(8'h01, 8'h02, 8'h04, 8'h08);
    run_cmd(1'b0, 8'h60, 1'b0, lat);
    @(negedge clk);
    chk("csum_m64", mem_m[8'h64], 8'h0F);
    load(1'b0, 8'h64, 8'h0E);
    load_rf4(8'h00, 8'h00, 8'h00, 8'h00);
    run_cmd(1'b1, 8'h60, 1'b0, lat);
    chk("csum_err_set", ctx_err, 1);
    @(negedge clk);
    chk("csum_err_sticky", ctx_err, 1);
    chk("csum_r3_restored", rf_m[3], 8'h08);
    load(1'b0, 8'h64, 8'h0F);
    run_cmd(1'b1, 8'h60, 1'b0, lat);
    chk("csum_err_clear", ctx_err, 0);
`endif

    chk("rd_wr_overlap", ovl_viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
